// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the byte-enabled dual-port RAM.
//   RDW_WRITE_FIRST / RDW_READ_FIRST : read-during-write policy codes
//   clr_state_t                      : zero-clear sweep FSM states
//   byte_merge()                     : replace the enabled bytes of a word
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // byte_merge works on a fixed maximum width so a single package function
    // serves every instance; callers zero-extend in and truncate out.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_NB = MERGE_MAX_W / 8;

    typedef enum logic {
        CLEAR,
        READY
    } clr_state_t;

    // Returns old_w with byte i replaced by new_w byte i wherever be[i] is set.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_NB-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: data + valid register chain used to stretch read latency.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_vld, in_data    : stage-0 read result
//   out_vld, out_data  : result delayed by STAGES cycles
// Data registers only load when the incoming valid is set, so the output
// holds the last delivered word between reads. STAGES = 0 is a wire.
module ram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] dat_pipe;

    assign vld_pipe[0] = in_vld;
    assign dat_pipe[0] = in_data;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stg
        logic             vld_q, vld_d;
        logic [WIDTH-1:0] dat_q, dat_d;

        always_comb begin
            vld_d = vld_pipe[s-1];
            dat_d = vld_pipe[s-1] ? dat_pipe[s-1] : dat_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign vld_pipe[s] = vld_q;
        assign dat_pipe[s] = dat_q;
    end

    if (STAGES == 0) begin : g_pass
        // Clock and reset have no load in the pass-through build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
    end

    assign out_vld  = vld_pipe[STAGES];
    assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port RAM (one write port, one read port, one clock)
// with per-byte write enables, 1- or 2-cycle read latency, selectable
// read-during-write policy and an optional zero-clear sweep after reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   we, waddr, wdata, wbe : write port, wbe[i] covers wdata[8i+7:8i]
//   re, raddr             : read port
//   rdata, rvalid         : read result, rvalid pulses once per accepted read
//   busy                  : clear sweep running, we/re ignored
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 256,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = RDW_WRITE_FIRST,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB = WIDTH / 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wbe,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > MERGE_MAX_W) begin : g_bad_width
        $error("ram_dp_be: WIDTH must be a multiple of 8 in 8..%0d", MERGE_MAX_W);
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("ram_dp_be: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("ram_dp_be: DEPTH must be at least 2");
    end

    localparam logic [AW:0]    DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam clr_state_t     RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    logic [WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Clear sweep FSM
    // ------------------------------------------------------------------
    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
                state_d = READY;
                ptr_d   = '0;
            end
        end
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Request qualification. Out-of-range addresses only exist when DEPTH
    // is not a power of two; such writes are dropped and reads return 0.
    // Memory writes are also held off while reset is asserted.
    // ------------------------------------------------------------------
    logic ready;
    logic wr_in_rng, rd_in_rng;
    logic wr_en, rd_en, clr_en;

    assign ready     = (state_q == READY);
    assign wr_in_rng = ({1'b0, waddr} < DEPTH_LIM);
    assign rd_in_rng = ({1'b0, raddr} < DEPTH_LIM);
    assign wr_en     = rst_n & ready & we & wr_in_rng;
    assign rd_en     = ready & re;
    assign clr_en    = rst_n & (state_q == CLEAR);

    // ------------------------------------------------------------------
    // Memory array: sweep has priority (it is the only writer while busy)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word with read-during-write bypass. In WRITE_FIRST the stored
    // word is merged with the enabled bytes of the concurrent write, which
    // matches what a later read of that address would see.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_word, rd_val;
    logic             rdw_hit;

    assign rd_word = mem[raddr];
    assign rdw_hit = wr_en && (waddr == raddr);

    always_comb begin
        rd_val = '0;
        if (rd_in_rng) begin
            if (RDW_MODE == RDW_WRITE_FIRST && rdw_hit) begin
                rd_val = WIDTH'(byte_merge(MERGE_MAX_W'(rd_word),
                                           MERGE_MAX_W'(wdata),
                                           MERGE_MAX_NB'(wbe)));
            end else begin
                rd_val = rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // First read register (latency 1); holds when no read is accepted
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
        rdata_d  = rd_en ? rd_val : rdata_q;
        rvalid_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Extra output stage(s) for RD_LAT = 2; a wire for RD_LAT = 1.
    ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LAT - 1)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rvalid_q),
        .in_data  (rdata_q),
        .out_vld  (rvalid),
        .out_data (rdata)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench for ram_dp_be. Three instances share one stimulus:
//   0: DEPTH 256, RD_LAT 1, WRITE_FIRST
//   1: DEPTH 256, RD_LAT 2, READ_FIRST
//   2: DEPTH 200, RD_LAT 1, WRITE_FIRST (out-of-range addresses 200..255)
// A reference model keeps word arrays and a table of results due per cycle.
module tb_ram_dp_be;

    localparam int ND = 3;
    localparam int DEP [ND] = '{256, 256, 200};
    localparam int LAT [ND] = '{1, 2, 1};
    localparam bit RDF [ND] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re;
    logic [7:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;

    logic [31:0] rdata_o  [ND];
    logic        rvalid_o [ND];
    logic        busy_o   [ND];

    always #5 clk = ~clk;

    ram_dp_be #(.WIDTH(32), .DEPTH(256), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .busy(busy_o[0]));

    ram_dp_be #(.WIDTH(32), .DEPTH(256), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .busy(busy_o[1]));

    ram_dp_be #(.WIDTH(32), .DEPTH(200), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]), .busy(busy_o[2]));

    // Reference model state
    logic [31:0] mdl  [ND][256];
    bit          pv   [ND][4];   // result due at check slot
    logic [31:0] pd   [ND][4];
    logic [31:0] last [ND];      // last delivered read data
    int          since_rst;      // clock edges since reset release
    int          ecnt;           // global edge counter for due slots
    int          bcnt [ND];      // cycles busy seen high since release

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    endtask

    task automatic rand_in();
        we    = 1'($urandom_range(0, 1));
        re    = 1'($urandom_range(0, 1));
        waddr = 8'($urandom_range(0, 255));
        raddr = ($urandom_range(0, 3) == 0) ? waddr : 8'($urandom_range(0, 255));
        wdata = $urandom;
        wbe   = 4'($urandom_range(0, 15));
    endtask

    // One clock: update the model with the current inputs, take the edge,
    // then compare every instance on the following falling edge.
    task automatic cyc();
        for (int k = 0; k < ND; k++) begin
            logic [31:0] old_w, new_w, res;
            int slot;
            if (since_rst < DEP[k]) begin
                mdl[k][since_rst] = 32'h0;
            end else begin
                if (re) begin
                    res = 32'h0;
                    if (int'(raddr) < DEP[k]) begin
                        old_w = mdl[k][raddr];
                        new_w = old_w;
                        if (we && waddr == raddr) begin
                            for (int b = 0; b < 4; b++)
                                if (wbe[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
                        end
                        res = RDF[k] ? old_w : new_w;
                    end
                    slot = (ecnt + LAT[k] - 1) % 4;
                    pv[k][slot] = 1'b1;
                    pd[k][slot] = res;
                end
                if (we && int'(waddr) < DEP[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (wbe[b]) mdl[k][waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        since_rst++;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            bit exp_v;
            exp_v = pv[k][ecnt % 4];
            if (exp_v) begin
                last[k] = pd[k][ecnt % 4];
                pv[k][ecnt % 4] = 1'b0;
            end
            if (busy_o[k]) bcnt[k]++;
            chk($sformatf("busy%0d", k),   32'(busy_o[k]),   32'(since_rst < DEP[k]));
            chk($sformatf("rvalid%0d", k), 32'(rvalid_o[k]), 32'(exp_v));
            chk($sformatf("rdata%0d", k),  rdata_o[k],       last[k]);
        end
        ecnt++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        idle_in(); we = 1'b1; waddr = a; wdata = d; wbe = be;
        cyc();
        idle_in();
    endtask

    task automatic rd(input logic [7:0] a);
        idle_in(); re = 1'b1; raddr = a;
        cyc();
        idle_in();
    endtask

    // Called at a falling edge with rst_n low: release and check busy.
    task automatic release_rst();
        rst_n = 1'b1;
        since_rst = 0;
        for (int k = 0; k < ND; k++) begin
            bcnt[k] = 0;
            if (busy_o[k]) bcnt[k]++;
            chk($sformatf("rel_busy%0d", k), 32'(busy_o[k]), 32'h1);
        end
    endtask

    // Called at a falling edge: assert reset mid-cycle, check the outputs
    // clear without a clock edge, then release on the next falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("arst_rdata%0d", k),  rdata_o[k],        32'h0);
            chk($sformatf("arst_rvalid%0d", k), 32'(rvalid_o[k]),  32'h0);
            chk($sformatf("arst_busy%0d", k),   32'(busy_o[k]),    32'h1);
            last[k] = 32'h0;
            for (int s = 0; s < 4; s++) pv[k][s] = 1'b0;
        end
        idle_in();
        @(posedge clk);
        @(negedge clk);
        release_rst();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        since_rst = 0;
        ecnt = 0;
        for (int k = 0; k < ND; k++) begin
            last[k] = 32'h0;
            bcnt[k] = 0;
            for (int s = 0; s < 4; s++) pv[k][s] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_rdata%0d", k),  rdata_o[k],       32'h0);
            chk($sformatf("rst_rvalid%0d", k), 32'(rvalid_o[k]), 32'h0);
            chk($sformatf("rst_busy%0d", k),   32'(busy_o[k]),   32'h1);
        end
        release_rst();

        // Sweep with random traffic that must be ignored while busy
        for (int i = 0; i < 256; i++) begin
            if (i < 200) rand_in(); else idle_in();
            cyc();
        end
        chk("busy_len0", 32'(bcnt[0]), 32'd256);
        chk("busy_len2", 32'(bcnt[2]), 32'd200);

        // Cleared contents
        rd(8'd0);   chk("clr_a0",   rdata_o[0], 32'h0);
        rd(8'd128); chk("clr_a128", rdata_o[0], 32'h0);
        rd(8'd255); chk("clr_a255", rdata_o[0], 32'h0);
        cyc();      chk("clr_b255", rdata_o[1], 32'h0);

        // Byte enables
        wr(8'd5, 32'hAABBCCDD, 4'hF);
        wr(8'd5, 32'h11223344, 4'b0101);
        rd(8'd5);
        chk("be_a", rdata_o[0], 32'hAA22CC44);
        chk("be_c", rdata_o[2], 32'hAA22CC44);
        cyc();
        chk("be_b", rdata_o[1], 32'hAA22CC44);

        // Same-address read and write in one cycle
        idle_in(); we = 1'b1; waddr = 8'd9; wdata = 32'hDEADBEEF; wbe = 4'hF;
        re = 1'b1; raddr = 8'd9;
        cyc();
        chk("rdw_wf_a", rdata_o[0], 32'hDEADBEEF);
        rd(8'd9);
        chk("rdw_rf_b", rdata_o[1], 32'h0);
        chk("rdw_nx_a", rdata_o[0], 32'hDEADBEEF);
        cyc();
        chk("rdw_nx_b", rdata_o[1], 32'hDEADBEEF);

        // Pipelined reads on the 2-cycle instance
        wr(8'd1, 32'h10, 4'hF);
        wr(8'd2, 32'h20, 4'hF);
        wr(8'd3, 32'h30, 4'hF);
        rd(8'd1); chk("pipe_v0", 32'(rvalid_o[1]), 32'h0);
        rd(8'd2); chk("pipe_d1", rdata_o[1], 32'h10);
        rd(8'd3); chk("pipe_d2", rdata_o[1], 32'h20);
        cyc();    chk("pipe_d3", rdata_o[1], 32'h30); chk("pipe_v3", 32'(rvalid_o[1]), 32'h1);
        cyc();    chk("pipe_hold", rdata_o[1], 32'h30); chk("pipe_v4", 32'(rvalid_o[1]), 32'h0);

        // Out-of-range access on the DEPTH=200 instance
        wr(8'd20, 32'h20202020, 4'hF);
        wr(8'd92, 32'h92929292, 4'hF);
        wr(8'd220, 32'hFFFFFFFF, 4'hF);
        rd(8'd220);
        chk("oor_rd", rdata_o[2], 32'h0);
        chk("oor_v", 32'(rvalid_o[2]), 32'h1);
        chk("inr_rd", rdata_o[0], 32'hFFFFFFFF);
        rd(8'd20); chk("oor_alias20", rdata_o[2], 32'h20202020);
        rd(8'd92); chk("oor_alias92", rdata_o[2], 32'h92929292);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rand_in();
            cyc();
        end
        idle_in();

        // Asynchronous reset while holding non-zero read data
        wr(8'd7, 32'h5A5A5A5A, 4'hF);
        rd(8'd7);
        chk("pre_rst_a", rdata_o[0], 32'h5A5A5A5A);
        do_reset();

        // Reset again when the sweep pointer reaches 100
        for (int i = 0; i < 100; i++) begin
            rand_in();
            cyc();
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i < 200) rand_in(); else idle_in();
            cyc();
        end
        chk("rebusy_len0", 32'(bcnt[0]), 32'd256);
        chk("rebusy_len1", 32'(bcnt[1]), 32'd256);
        chk("rebusy_len2", 32'(bcnt[2]), 32'd200);

        for (int i = 0; i < 300; i++) begin
            rand_in();
            cyc();
        end
        idle_in();
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
